// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle digit-serial adder/subtractor with start/busy/done handshake
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    // Counter is at least one bit wide so the single-digit case still elaborates.
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Latched operands; B is stored already inverted for subtraction so the
    // digit slice only ever performs an addition.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [IW-1:0]    idx;

    logic             accept;
    logic             last_dig;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // A new request is taken whenever the adder is not mid-operation.
    assign accept   = start && (state != S_RUN);
    assign last_dig = (idx == IW'(NDIG - 1));

    // One digit of ripple-carry addition; also tracks the carry into the top
    // bit of the digit, which on the last digit is the carry into the MSB.
    always_comb begin
        logic c;
        dig_a    = op_a[int'(idx)*DIGIT +: DIGIT];
        dig_b    = op_b[int'(idx)*DIGIT +: DIGIT];
        dig_s    = '0;
        dig_cmsb = 1'b0;
        c        = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dig_s[i] = dig_a[i] ^ dig_b[i] ^ c;
            if (i == DIGIT - 1) begin
                dig_cmsb = c;
            end
            c = (dig_a[i] & dig_b[i]) | (c & (dig_a[i] ^ dig_b[i]));
        end
        dig_cout = c;
    end

    // Accumulator with the current digit merged in; on the final digit this
    // is the full result written to the output register.
    always_comb begin
        acc_nxt = acc;
        acc_nxt[int'(idx)*DIGIT +: DIGIT] = dig_s;
    end

    // Next-state logic: RUN lasts NDIG cycles, DONE exactly one.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_dig) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and digit-serial datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            acc   <= '0;
            idx   <= '0;
        end else if (state == S_RUN) begin
            acc   <= acc_nxt;
            carry <= dig_cout;
            idx   <= last_dig ? '0 : idx + IW'(1);
        end
    end

    // Result registers: written only on the RUN->DONE edge, then held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if ((state == S_RUN) && last_dig) begin
            sum_q  <= acc_nxt;
            cout_q <= dig_cout;
            ovf_q  <= dig_cmsb ^ dig_cout;
        end
    end

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed and exhaustive-sweep bench for digit_serial_adder
module tb_digit_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    logic        start2;
    logic [3:0]  a2;
    logic [3:0]  b2;
    logic        cin2;
    logic        sub2;
    logic        busy2;
    logic        done2;
    logic [3:0]  sum2;
    logic        cout2;
    logic        overflow2;

    int vec_cnt = 0;
    int err_cnt = 0;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .a        (a2),
        .b        (b2),
        .cin      (cin2),
        .sub      (sub2),
        .busy     (busy2),
        .done     (done2),
        .sum      (sum2),
        .cout     (cout2),
        .overflow (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one operation and checks busy cycles 1..4, done in cycle 5 and the result.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub,
                         input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check({tag, "_done"}, {30'd0, busy, done}, 32'b01);
        check({tag, "_res"}, {14'd0, overflow, cout, sum}, {14'd0, eo, ec, es});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       seen_done;
        logic [3:0] bb;
        logic       ci;
        logic [4:0] r5;
        logic       eovf;

        rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
        start2 = 1'b0; a2 = 4'h0; b2 = 4'h0; cin2 = 1'b0; sub2 = 1'b0;

        // 1: reset held with start asserted
        repeat (2) @(negedge clk);
        check("rst_state", {13'd0, busy, done, overflow, cout, sum}, 32'd0);
        check("rst_state4", {25'd0, busy2, done2, overflow2, cout2, sum2}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_norun", {31'd0, busy}, 32'd0);

        // 2..4: directed arithmetic
        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("add_cin",   16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);

        // 6: reset in second RUN cycle
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out", {13'd0, busy, done, overflow, cout, sum}, 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("midrst_nodone", {31'd0, seen_done}, 32'd0);

        // 5: start held through RUN is ignored; start in DONE is accepted
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b1;
        end
        @(negedge clk);
        check("b2b_first", {13'd0, done, overflow, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h3334});
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_hold", {16'd0, sum}, 32'h3334);
        @(negedge clk);
        check("b2b_second", {13'd0, done, overflow, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h1010});

        // Exhaustive sweep of the 4-bit / 2-bit-digit instance
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            a2 = i[3:0]; b2 = i[7:4]; cin2 = i[8]; sub2 = i[9];
            start2 = 1'b1;
            bb = sub2 ? ~b2 : b2;
            ci = sub2 ? 1'b1 : cin2;
            r5 = {1'b0, a2} + {1'b0, bb} + {4'd0, ci};
            eovf = (a2[3] == bb[3]) && (r5[3] != a2[3]);
            @(negedge clk);
            start2 = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (done2) break;
                @(negedge clk);
            end
            check("sweep", {25'd0, done2, overflow2, cout2, sum2}, {25'd0, 1'b1, eovf, r5});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
